hilo_unit: RTL

Sequencer and HI/LO register pair sitting directly downstream of the iterative divider and multiplier in the datapath. It accepts a single-cycle operation request from the control unit and re-arms the divider with a clear pulse before launching it. It waits for completion, then latches the 64-bit result into HI/LO for mfhi/mflo. It also handles direct mthi/mtlo writes and reports divide-by-zero as an exception flag.

---
 rtl/hilo_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hilo_unit.sv
// HI/LO register pair and sequencer for the iterative divider/multiplier.
// Optional WAIT watchdog is enabled by defining HILO_TIMEOUT_EN.
module hilo_unit #(
  parameter logic [31:0] TIMEOUT = 32'd64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] div_hi_i,
  input  logic [31:0] div_lo_i,
  input  logic        div_done_i,
  input  logic        div0_i,
  input  logic [31:0] mult_hi_i,
  input  logic [31:0] mult_lo_i,
  input  logic        mult_done_i,
  output logic        div_clr_o,
  output logic        div_ctrl_o,
  output logic        mult_ctrl_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div0_exc_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [2:0]  state_o
);

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_WRITE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic [31:0] hi_q, lo_q;
  logic        skip_q;
  logic        div0_exc_q;
  logic        mt_done_q;
  logic        capture;
  logic        abort;
  logic        accept;

  assign accept = (state_q == S_IDLE) && start_i;

`ifdef HILO_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        wd_expired;
  // wd_q holds the number of WAIT cycles already completed.
  assign wd_expired = (wd_q == TIMEOUT - 32'd1);
`else
  logic        wd_expired;
  logic        unused_timeout;
  assign wd_expired     = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && op_i == OP_DIV)       state_d = S_CLR;
        else if (start_i && op_i == OP_MULT) state_d = S_LAUNCH;
      end
      S_CLR:    state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // Only the launched unit's completion counts; Div0 beats DivDone.
        if (op_q == OP_DIV) begin
          if (div0_i)          abort   = 1'b1;
          else if (div_done_i) capture = 1'b1;
        end else if (mult_done_i) begin
          capture = 1'b1;
        end
        if (!capture && !abort && wd_expired) abort = 1'b1;
        if (capture || abort) state_d = S_WRITE;
      end
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      op_q       <= OP_DIV;
      res_hi_q   <= 32'd0;
      res_lo_q   <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      skip_q     <= 1'b0;
      div0_exc_q <= 1'b0;
      mt_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_done_q <= accept && op_i[1];
      if (accept) begin
        op_q       <= op_i;
        div0_exc_q <= 1'b0;
        if (op_i == OP_MTHI) hi_q <= wr_data_i;
        if (op_i == OP_MTLO) lo_q <= wr_data_i;
      end
      if (capture) begin
        res_hi_q <= (op_q == OP_DIV) ? div_hi_i : mult_hi_i;
        res_lo_q <= (op_q == OP_DIV) ? div_lo_i : mult_lo_i;
        skip_q   <= 1'b0;
      end
      if (abort) begin
        div0_exc_q <= 1'b1;
        skip_q     <= 1'b1;
      end
      if (state_q == S_WRITE && !skip_q) begin
        hi_q <= res_hi_q;
        lo_q <= res_lo_q;
      end
    end
  end

`ifdef HILO_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                        wd_q <= 32'd0;
    else if (state_q == S_WAIT && state_d == S_WAIT)    wd_q <= wd_q + 32'd1;
    else                                                wd_q <= 32'd0;
  end
`endif

  assign div_clr_o   = (state_q == S_CLR);
  assign div_ctrl_o  = (state_q == S_LAUNCH) && (op_q == OP_DIV);
  assign mult_ctrl_o = (state_q == S_LAUNCH) && (op_q == OP_MULT);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_WRITE) || mt_done_q;
  assign div0_exc_o  = div0_exc_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign state_o     = state_q;

endmodule
